fwd_scoreboard: RTL and testbench

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It keeps a shift-register history of in-flight register writes and matches the two source registers of the instruction in ID against it. For each source it produces a registered forward select, aligned with the instruction's arrival in EX, and a combinational stall request. It generalises the fixed two-stage EX/MEM-vs-MEM/WB forwarding by adding:
- configurable forwarding depth,
- configurable load latency,
- stall, flush and hold handling.

---
 rtl/fwd_scoreboard.sv | 94 +++++++++
 tb/tb_fwd_scoreboard.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard unit: shift-register history of in-flight writes
// matched against ID sources. Optional stall counter under FWD_PERF_CNT_EN.
module fwd_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [31:0]       stall_cycles
);

  logic [DEPTH:1]    r_v;
  logic [DEPTH:1]    r_ld;
  logic [REG_AW-1:0] r_rd [1:DEPTH];
  logic [SEL_W-1:0]  r_sel_a;
  logic [SEL_W-1:0]  r_sel_b;

  logic              w_haz_a;
  logic              w_haz_b;
  logic [SEL_W-1:0]  w_cand_a;
  logic [SEL_W-1:0]  w_cand_b;
  logic              w_stall;
  logic              w_issue;

  // Scan oldest to youngest so the youngest match overrides; returns {hazard, select}.
  function automatic logic [SEL_W:0] resolve(input logic [REG_AW-1:0] s);
    logic [SEL_W:0] res;
    res = '0;
    for (int unsigned p = DEPTH; p >= 1; p--) begin
      if (r_v[p] && (r_rd[p] == s) && (s != '0))
        res = {r_ld[p] && (int'(p) <= LOAD_LAT), SEL_W'(p)};
    end
    return res;
  endfunction

  always_comb begin
    {w_haz_a, w_cand_a} = resolve(id_rs);
    {w_haz_b, w_cand_b} = resolve(id_rt);
    w_stall = id_valid & ~id_flush & (w_haz_a | w_haz_b);
    w_issue = id_valid & ~id_flush & ~w_stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v     <= '0;
      r_sel_a <= '0;
      r_sel_b <= '0;
    end else if (!hold) begin
      for (int unsigned p = DEPTH; p >= 2; p--) begin
        r_v[p]  <= r_v[p-1];
        r_rd[p] <= r_rd[p-1];
        r_ld[p] <= r_ld[p-1];
      end
      r_v[1]  <= w_issue & id_regwrite & (id_rd != '0);
      r_rd[1] <= id_rd;
      r_ld[1] <= id_memread;
      r_sel_a <= w_issue ? w_cand_a : '0;
      r_sel_b <= w_issue ? w_cand_b : '0;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cycles <= '0;
    else if (w_stall && !hold)
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

  assign stall     = w_stall;
  assign fwd_sel_a = r_sel_a;
  assign fwd_sel_b = r_sel_b;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: default instance plus a DEPTH=3/LOAD_LAT=2 instance.
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1, hold = 1'b0, flush = 1'b0, rw = 1'b0, mr = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic        stall0, stall1;
  logic [1:0]  sa0, sb0, sa1, sb1;
  logic [31:0] cnt0, cnt1;

  always #5 clk = ~clk;

  fwd_scoreboard u_dut0 (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(v0),
    .id_rs(rs), .id_rt(rt), .id_rd(rd), .id_regwrite(rw), .id_memread(mr),
    .id_flush(flush), .stall(stall0), .fwd_sel_a(sa0), .fwd_sel_b(sb0),
    .stall_cycles(cnt0)
  );

  fwd_scoreboard #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(2)) u_dut1 (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(v1),
    .id_rs(rs), .id_rt(rt), .id_rd(rd), .id_regwrite(rw), .id_memread(mr),
    .id_flush(flush), .stall(stall1), .fwd_sel_a(sa1), .fwd_sel_b(sb1),
    .stall_cycles(cnt1)
  );

  typedef struct {
    int    cyc;
    int    dut;
    int    kind;
    int    val;
    string nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int d, input int k);
    if (d == 0) begin
      case (k)
        0:       return {31'b0, stall0};
        1:       return {30'b0, sa0};
        2:       return {30'b0, sb0};
        default: return cnt0;
      endcase
    end else begin
      case (k)
        0:       return {31'b0, stall1};
        1:       return {30'b0, sa1};
        2:       return {30'b0, sb1};
        default: return cnt1;
      endcase
    end
  endfunction

  // Monitor: pops every expectation due in the current cycle and compares.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.dut, e.kind);
      n_cmp++;
      if (e.cyc != cyc || a !== e.val) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%0d want=%0d", e.nm, cyc, a, e.val);
      end
    end
  end

  task automatic push(input int c, input int d, input int k, input int val, input string nm);
    exp_t e;
    e.cyc = c; e.dut = d; e.kind = k; e.val = val; e.nm = nm;
    q.push_back(e);
  endtask

  // One ID cycle on instance d; est < 0 skips the stall check.
  task automatic step(input int d, input bit r, input bit v, input int s1, input int s2,
                      input int dst, input bit w, input bit m, input bit fl, input bit hd,
                      input int est, input int esa, input int esb, input string nm);
    @(posedge clk);
    #1;
    reset = r;
    v0    = (d == 0) && v;
    v1    = (d == 1) && v;
    rs    = 5'(s1);
    rt    = 5'(s2);
    rd    = 5'(dst);
    rw    = w;
    mr    = m;
    flush = fl;
    hold  = hd;
    if (est >= 0) push(cyc, d, 0, est, {nm, ".stall"});
    push(cyc + 1, d, 1, esa, {nm, ".sel_a"});
    push(cyc + 1, d, 2, esb, {nm, ".sel_b"});
    if (r) begin
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
    end else if (est == 1 && !hd) begin
      exp_cnt[d]++;
    end
`ifdef FWD_PERF_CNT_EN
    push(cyc + 1, d, 3, exp_cnt[d], {nm, ".stall_cycles"});
`else
    push(cyc + 1, d, 3, 0, {nm, ".stall_cycles"});
`endif
  endtask

  initial begin
    //   d  r  v  rs rt rd  w  m  fl hd est sa sb
    step(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, -1, 0, 0, "reset");
    step(0, 0, 1, 1, 2, 3,  1, 0, 0, 0,  0, 0, 0, "alu_prod");
    step(0, 0, 1, 3, 6, 7,  1, 0, 0, 0,  0, 1, 0, "alu_use");
    step(0, 0, 1, 1, 0, 4,  1, 1, 0, 0,  0, 0, 0, "lw4");
    step(0, 0, 1, 5, 4, 8,  1, 0, 0, 0,  1, 0, 0, "lu_stall");
    step(0, 0, 1, 5, 4, 8,  1, 0, 0, 0,  0, 0, 2, "lu_issue");
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, "wr5a");
    step(0, 0, 1, 5, 5, 0,  0, 0, 0, 0,  0, 1, 1, "young_p1");
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, "wr5b");
    step(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, "bub1");
    step(0, 0, 1, 5, 5, 0,  0, 0, 0, 0,  0, 2, 2, "young_p2");
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, "wr5c");
    step(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, "bub2a");
    step(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, "bub2b");
    step(0, 0, 1, 5, 5, 0,  0, 0, 0, 0,  0, 0, 0, "retired");
    step(0, 0, 1, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, "ld_zero");
    step(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, "rd_zero");
    step(0, 0, 1, 0, 0, 9,  1, 1, 0, 0,  0, 0, 0, "lw9");
    step(0, 0, 1, 0, 9, 10, 1, 0, 1, 0,  0, 0, 0, "flush");
    step(0, 0, 1, 9, 9, 11, 1, 1, 0, 0,  0, 2, 2, "post_flush");
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 11, 0, 12, 1, 0, 0, 1, 1, 2, 2, "hold");
    step(0, 0, 1, 11, 0, 12, 1, 0, 0, 0,  1, 0, 0, "hold_stall");
    step(0, 0, 1, 11, 0, 12, 1, 0, 0, 0,  0, 2, 0, "hold_release");
    step(0, 0, 1, 0, 0, 13, 1, 1, 0, 0,  0, 0, 0, "lw13");
    step(0, 1, 1, 13, 0, 14, 1, 0, 0, 0,  1, 0, 0, "rst_stalled");
    step(0, 0, 1, 13, 0, 14, 1, 0, 0, 0,  0, 0, 0, "rst_release");
    step(1, 0, 1, 0, 0, 6,  1, 1, 0, 0,  0, 0, 0, "deep_lw");
    step(1, 0, 1, 6, 6, 7,  1, 0, 0, 0,  1, 0, 0, "deep_stall1");
    step(1, 0, 1, 6, 6, 7,  1, 0, 0, 0,  1, 0, 0, "deep_stall2");
    step(1, 0, 1, 6, 6, 7,  1, 0, 0, 0,  0, 3, 3, "deep_issue");
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, "deep_idle");
    repeat (3) @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL pending_expectations left=%0d want=0", q.size());
      n_cmp += q.size();
      n_bad += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
